// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte-stream
// requesters. Round-robin selection; the winner keeps the transmitter until it
// sends EOP_CHAR, hits MAX_BURST bytes, or stays idle for IDLE_TIMEOUT cycles.
// One registered output slot sits in front of the uart_tx valid/ready port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no owner; arbitrate among valid requesters
// S_LOCKED | owner streams bytes into the output slot
// S_DRAIN  | owner released; wait for the held byte to leave, then go idle
module uart_tx_arbiter #(
  parameter int                NUM_REQ      = 2,
  parameter int                WIDTH        = 8,
  parameter logic [WIDTH-1:0]  EOP_CHAR     = WIDTH'(8'h0A),
  parameter int                MAX_BURST    = 16,
  parameter int                IDLE_TIMEOUT = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]         o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic                     o_busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCKED = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant;
  logic [GW-1:0]      grant_idx;
  logic [GW-1:0]      last_owner;
  logic [BW-1:0]      burst_cnt;
  logic [TW-1:0]      idle_cnt;
  logic [WIDTH-1:0]   tx_data;
  logic               tx_valid;

  logic               arb_found;
  logic [GW-1:0]      arb_idx;
  logic [GW-1:0]      cand;
  logic               sel_valid;
  logic [WIDTH-1:0]   sel_data;
  logic               slot_free;
  logic               req_xfer;
  logic               tx_xfer;
  logic               eop_hit;
  logic               burst_hit;
  logic               timeout_hit;

  // Round-robin pick: first valid requester searching upward from last_owner+1.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_owner) + i) % NUM_REQ);
      if (!arb_found && i_req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Mux the owner's valid/data using the one-hot grant register.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_valid = i_req_valid[k];
        sel_data  = i_req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready depends only on registered state and i_tx_ready, never on valid,
  // so there is no combinational path from requester valid back to ready.
  assign slot_free   = !tx_valid || i_tx_ready;
  assign o_req_ready = (state == S_LOCKED && slot_free) ? grant : '0;
  assign req_xfer    = (state == S_LOCKED) && slot_free && sel_valid;
  assign tx_xfer     = tx_valid && i_tx_ready;
  assign eop_hit     = (sel_data == EOP_CHAR);
  assign burst_hit   = (MAX_BURST != 0) && ((int'(burst_cnt) + 1) == MAX_BURST);
  assign timeout_hit = (IDLE_TIMEOUT != 0) && (int'(idle_cnt) == IDLE_TIMEOUT - 1);

  // Arbitration FSM with the registered output slot and grant/counter state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      last_owner <= GW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      idle_cnt   <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            grant     <= NUM_REQ'(1) << arb_idx;
            grant_idx <= arb_idx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            state     <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (req_xfer) begin
            tx_data   <= sel_data;
            tx_valid  <= 1'b1;
            burst_cnt <= burst_cnt + 1'b1;
            idle_cnt  <= '0;
            if (eop_hit || burst_hit) begin
              state <= S_DRAIN;
            end
          end else begin
            if (tx_xfer) begin
              tx_valid <= 1'b0;
            end
            if (!sel_valid) begin
              idle_cnt <= idle_cnt + 1'b1;
              if (timeout_hit) begin
                state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!tx_valid || tx_xfer) begin
            tx_valid   <= 1'b0;
            last_owner <= grant_idx;
            grant      <= '0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign o_tx_data  = tx_data;
  assign o_tx_valid = tx_valid;
  assign o_grant    = grant;
  assign o_busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, directed scenarios and
// randomized traffic checked against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int          NREQ = 2;
  localparam int          MAXB = 4;
  localparam int          TOUT = 8;
  localparam logic [7:0]  EOP  = 8'h0A;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;

  uart_tx_arbiter #(
    .NUM_REQ(NREQ), .WIDTH(8), .EOP_CHAR(EOP), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready), .o_grant(grant), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       txr;
    logic [1:0] g;
    logic [1:0] r;
    logic       txv;
    logic [7:0] txd;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  logic [7:0] srcq [NREQ][$];
  logic [7:0] expq[$];
  logic [7:0] txlog[$];
  int         acc_req[$];
  logic [7:0] acc_byte[$];
  logic [1:0] glog[$];

  int         m_last, seg_owner, seg_cnt, streak;
  bit         seg_closed;
  logic [1:0] p_g, p_v;
  logic       p_txv, p_txr;
  logic [7:0] p_txd;
  bit   [1:0] en;
  int         txr_pct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                      input logic txr, input logic [1:0] g, input logic [1:0] rd, input logic txv,
                      input logic [7:0] txd, input logic b);
    vec_t e;
    e.rst = r; e.v = v; e.d0 = d0; e.d1 = d1; e.txr = txr;
    e.g = g; e.r = rd; e.txv = txv; e.txd = txd; e.busy = b;
    vq.push_back(e);
  endtask

  function automatic int idx_of(input logic [1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Round-robin rule: first valid index upward from last+1, wrapping.
  function automatic logic [1:0] rr_pick(input logic [1:0] v, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      int c;
      c = (last + i) % NREQ;
      if (v[c]) return 2'(1 << c);
    end
    return 2'b00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_data = '0; tx_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_last = NREQ - 1; seg_owner = -1; seg_cnt = 0; streak = 0; seg_closed = 1'b1;
    p_g = '0; p_v = '0; p_txv = 1'b0; p_txr = 1'b0; p_txd = '0;
    for (int k = 0; k < NREQ; k++) srcq[k].delete();
    expq.delete(); txlog.delete(); acc_req.delete(); acc_byte.delete(); glog.delete();
    en = '0; txr_pct = 100;
  endtask

  // One clock cycle: drive from the source queues, then check against the model.
  task automatic step();
    logic [1:0]  v, acc;
    logic [15:0] d;
    logic [7:0]  b;
    int          k;
    @(negedge clk);
    v = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        v[i] = 1'b1;
        d[i*8 +: 8] = srcq[i][0];
      end
    end
    req_valid = v; req_data = d;
    tx_ready = ($urandom_range(0, 99) < txr_pct);
    #1;
    chk("grant_onehot", $onehot0(grant), 1);
    chk("ready_onehot", $onehot0(req_ready), 1);
    chk("ready_in_grant", req_ready & ~grant, 0);
    chk("busy_vs_grant", busy, grant != 2'b00);
    if (p_txv && !p_txr) begin
      chk("hold_valid", tx_valid, 1);
      chk("hold_data", tx_data, p_txd);
    end
    if (p_g != 2'b00 && grant != p_g) begin
      chk("release_cond", seg_closed, 1);
      chk("release_to_idle", grant, 0);
      m_last = idx_of(p_g);
      seg_owner = -1;
    end
    if (p_g == 2'b00) begin
      if (p_v != 2'b00) begin
        logic [1:0] e;
        e = rr_pick(p_v, m_last);
        chk("arb_pick", grant, e);
        glog.push_back(grant);
        seg_owner = idx_of(e); seg_cnt = 0; streak = 0; seg_closed = 1'b0;
      end else begin
        chk("no_spurious_grant", grant, 0);
      end
    end
    if (grant != 2'b00 && !seg_closed && seg_owner >= 0 && !req_valid[seg_owner]) begin
      streak++;
      if (streak == TOUT) seg_closed = 1'b1;
    end
    if (tx_valid && tx_ready) begin
      chk("tx_queue_nonempty", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        b = expq.pop_front();
        chk("tx_byte", tx_data, b);
        txlog.push_back(tx_data);
      end
    end
    acc = req_ready & req_valid;
    if (acc != 2'b00) begin
      k = idx_of(acc);
      chk("accept_owner", k, seg_owner);
      chk("accept_open", seg_closed, 0);
      b = srcq[k].pop_front();
      expq.push_back(b); acc_req.push_back(k); acc_byte.push_back(b);
      seg_cnt++; streak = 0;
      if (b == EOP || seg_cnt == MAXB) seg_closed = 1'b1;
    end
    p_g = grant; p_v = req_valid; p_txv = tx_valid; p_txr = tx_ready; p_txd = tx_data;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (srcq[0].size() == 0 && srcq[1].size() == 0 && expq.size() == 0 &&
          grant == 2'b00 && !tx_valid) break;
      step();
    end
    chk("settle_grant", grant, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_b[$];
    int         exp_r[$];
    int         cnt;

    // rst v d0 d1 txr | grant ready txv txd busy
    addv(1'b0, 2'b01, 8'h48, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    addv(1'b0, 2'b01, 8'h48, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 1'b1);
    addv(1'b0, 2'b01, 8'h49, 8'h00, 1'b1, 2'b01, 2'b01, 1'b1, 8'h48, 1'b1);
    addv(1'b0, 2'b01, 8'h0A, 8'h00, 1'b1, 2'b01, 2'b01, 1'b1, 8'h49, 1'b1);
    addv(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b00, 1'b1, 8'h0A, 1'b1);
    addv(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h0A, 1'b0);
    addv(1'b0, 2'b11, 8'h41, 8'h42, 1'b1, 2'b00, 2'b00, 1'b0, 8'h0A, 1'b0);
    addv(1'b0, 2'b11, 8'h41, 8'h42, 1'b1, 2'b10, 2'b10, 1'b0, 8'h0A, 1'b1);
    addv(1'b0, 2'b11, 8'h41, 8'h0A, 1'b1, 2'b10, 2'b10, 1'b1, 8'h42, 1'b1);
    addv(1'b0, 2'b01, 8'h41, 8'h00, 1'b1, 2'b10, 2'b00, 1'b1, 8'h0A, 1'b1);
    addv(1'b0, 2'b01, 8'h41, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h0A, 1'b0);
    addv(1'b0, 2'b01, 8'h41, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h0A, 1'b1);
    addv(1'b1, 2'b01, 8'h0A, 8'h00, 1'b1, 2'b01, 2'b01, 1'b1, 8'h41, 1'b1);
    addv(1'b0, 2'b11, 8'h33, 8'h55, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    addv(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 1'b1);

    rst = 1'b1; req_valid = '0; req_data = '0; tx_ready = 1'b1;
    do_reset();
    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; req_valid = vq[i].v; req_data = {vq[i].d1, vq[i].d0}; tx_ready = vq[i].txr;
      #1;
      chk($sformatf("vec%0d_grant", i), grant, vq[i].g);
      chk($sformatf("vec%0d_ready", i), req_ready, vq[i].r);
      chk($sformatf("vec%0d_txv", i), tx_valid, vq[i].txv);
      chk($sformatf("vec%0d_txd", i), tx_data, vq[i].txd);
      chk($sformatf("vec%0d_busy", i), busy, vq[i].busy);
    end

    // Reset then nothing requested.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_grant", grant, 0);
      chk("idle_txv", tx_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 0);
    end

    // Round-robin contention: "A\n" and "B\n" streamed by both requesters.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      srcq[0].push_back(8'h41); srcq[0].push_back(EOP);
      srcq[1].push_back(8'h42); srcq[1].push_back(EOP);
    end
    en = 2'b11;
    wait_idle(200);
    chk("rr_len", txlog.size(), 12);
    for (int i = 0; i < 6 && 2*i+1 < txlog.size(); i++) begin
      chk($sformatf("rr_byte%0d", 2*i), txlog[2*i], (i % 2 == 1) ? 8'h42 : 8'h41);
      chk($sformatf("rr_eop%0d", 2*i+1), txlog[2*i+1], EOP);
    end
    chk("rr_grants", glog.size(), 6);
    for (int i = 0; i < glog.size() && i < 6; i++)
      chk($sformatf("rr_grant%0d", i), glog[i], (i % 2 == 1) ? 2'b10 : 2'b01);

    // Backpressure mid-message.
    do_reset();
    srcq[0].push_back(8'h31); srcq[0].push_back(8'h32); srcq[0].push_back(EOP);
    en = 2'b01;
    repeat (3) step();
    txr_pct = 0;
    cnt = 0;
    repeat (50) begin
      step();
      if (req_ready != 2'b00) cnt++;
    end
    chk("bp_ready_low", cnt, 0);
    chk("bp_data_held", tx_data, 8'h32);
    chk("bp_valid_held", tx_valid, 1);
    txr_pct = 100;
    wait_idle(50);
    chk("bp_len", txlog.size(), 3);
    exp_b = '{8'h31, 8'h32, 8'h0A};
    for (int i = 0; i < txlog.size() && i < 3; i++)
      chk($sformatf("bp_byte%0d", i), txlog[i], exp_b[i]);

    // Idle timeout: one byte then valid drops.
    do_reset();
    srcq[1].push_back(8'h77);
    en = 2'b10;
    cnt = 0;
    repeat (20) begin
      step();
      if (grant != 2'b00 && !req_valid[1]) cnt++;
    end
    chk("timeout_cycles", cnt, TOUT + 1);
    chk("timeout_released", grant, 0);
    chk("timeout_len", txlog.size(), 1);

    // Burst limit: requester 1 sends 10 bytes without EOP while 0 waits.
    do_reset();
    for (int i = 0; i < 10; i++) srcq[1].push_back(8'(8'h60 + i));
    en = 2'b11;
    step();
    srcq[0].push_back(8'h30); srcq[0].push_back(EOP);
    wait_idle(300);
    exp_b = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h30, 8'h0A, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
    exp_r = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    chk("burst_len", acc_byte.size(), 12);
    for (int i = 0; i < acc_byte.size() && i < 12; i++) begin
      chk($sformatf("burst_byte%0d", i), acc_byte[i], exp_b[i]);
      chk($sformatf("burst_req%0d", i), acc_req[i], exp_r[i]);
    end
    chk("burst_grants", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("burst_g0", glog[0], 2'b10);
      chk("burst_g1", glog[1], 2'b01);
      chk("burst_g2", glog[2], 2'b10);
      chk("burst_g3", glog[3], 2'b10);
    end

    // Randomized traffic against the reference model.
    do_reset();
    en = 2'b11;
    txr_pct = 60;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        int k, len;
        k = $urandom_range(0, NREQ - 1);
        if (srcq[k].size() < 30) begin
          len = $urandom_range(1, 6);
          for (int j = 0; j < len; j++) srcq[k].push_back(8'($urandom_range(0, 255)));
          if ($urandom_range(0, 1) == 1) srcq[k].push_back(EOP);
        end
      end
      for (int k = 0; k < NREQ; k++)
        if ($urandom_range(0, 19) == 0) en[k] = ~en[k];
      step();
    end
    en = 2'b11;
    txr_pct = 100;
    wait_idle(3000);
    chk("rand_src0_empty", srcq[0].size(), 0);
    chk("rand_src1_empty", srcq[1].size(), 0);
    chk("rand_exp_empty", expq.size(), 0);
    chk("rand_tx_count", txlog.size(), acc_byte.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. the case-converted echo FIFO and a status/banner message source.
- Arbitration is round-robin with message locking. A granted requester keeps the transmitter until it sends EOP_CHAR, reaches MAX_BURST bytes, or goes idle for IDLE_TIMEOUT cycles.
- Sits between the requester FIFOs and the uart_tx valid/ready input. It contains one registered output stage.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 8, data width per requester.
- EOP_CHAR, 8'h0A, end-of-message byte that releases the lock.
- MAX_BURST, 16, maximum bytes per grant. 0 disables the limit.
- IDLE_TIMEOUT, 255, cycles with the granted requester not valid before a forced release. 0 disables the timeout.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous reset, active-high.
- i_req_valid  input  NUM_REQ  per-requester byte valid.
- i_req_data  input  NUM_REQ*WIDTH  requester k occupies bits [k*WIDTH +: WIDTH].
- o_req_ready  output  NUM_REQ  per-requester accept.
- o_tx_data  output  WIDTH  byte to uart_tx.
- o_tx_valid  output  1  byte valid to uart_tx.
- i_tx_ready  input  1  uart_tx can accept.
- o_grant  output  NUM_REQ  one-hot current owner. All zero when idle.
- o_busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (i_rst high at clock edge):
  - state=IDLE; o_grant=0; o_tx_valid=0; o_tx_data=0; o_busy=0.
  - Burst and idle counters cleared.
  - Round-robin pointer set so requester 0 has highest priority on the first arbitration.
  - Reset mid-message discards any held byte. Nothing in flight is completed.
- States: IDLE, LOCKED, DRAIN.
- Transfers:
  - Requester transfer: o_req_ready[k] && i_req_valid[k].
  - TX transfer: o_tx_valid && i_tx_ready.
- IDLE:
  - o_req_ready=0.
  - If any i_req_valid is set, select the first valid index searching upward from (last_owner+1) mod NUM_REQ, with wrap-around.
  - Next cycle: o_grant is set, state=LOCKED, counters=0.
- LOCKED:
  - o_req_ready[g] = (!o_tx_valid || i_tx_ready). All other ready bits are 0, so requesters stall at most one registered slot.
  - Ready is combinational from registered state and i_tx_ready only. It must not depend on i_req_valid.
  - On a requester transfer: o_tx_data <= byte, o_tx_valid <= 1, burst_cnt += 1, idle_cnt cleared.
  - On a TX transfer with no requester transfer in the same cycle: o_tx_valid <= 0.
  - Simultaneous TX and requester transfers give back-to-back bytes with no bubble.
  - Release condition in the accept cycle: byte==EOP_CHAR, or (MAX_BURST!=0 and burst_cnt+1==MAX_BURST). On release, go to DRAIN.
  - Timeout: if i_req_valid[g] is low, idle_cnt increments. When IDLE_TIMEOUT!=0 and idle_cnt reaches IDLE_TIMEOUT-1, go to DRAIN.
- DRAIN:
  - o_req_ready=0.
  - When o_tx_valid==0, or a TX transfer occurs this cycle: last_owner <= g, o_grant <= 0, state=IDLE.
  - Re-arbitration is allowed at the earliest in the following cycle.
- Latency:
  - Valid at cycle t in IDLE gives o_grant at t+1.
  - First byte is accepted at t+1 and o_tx_valid is high at t+2.
  - Minimum release-to-next-grant gap is 2 cycles.
- Invariants:
  - o_grant is one-hot or zero.
  - At most one o_req_ready bit is high.
  - o_tx_valid, once high, stays high with o_tx_data stable until i_tx_ready.
  - Non-granted requesters are never dropped. Their valid must simply persist.
- Fairness: every continuously-valid requester is granted within NUM_REQ-1 other grants.

Test Plan:
- Reset/idle: reset then no requests -> o_grant=0, o_tx_valid=0, o_busy=0, all ready=0 for 20 cycles.
- Single message: requester 0 sends "HI\n" (48,49,0A), i_tx_ready held 1 -> o_tx_data 48,49,0A on consecutive cycles from t+2; DRAIN then IDLE; o_grant returns 0.
- Round-robin contention:
  - Both requesters stream "A\n" and "B\n" continuously -> TX order A,0A,B,0A,A,0A...
  - Grants alternate 01,10,01.
- Backpressure: i_tx_ready low for 50 cycles mid-message -> o_tx_data and o_tx_valid held stable; o_req_ready[g]=0; no byte lost or duplicated.
- Burst limit: MAX_BURST=4, requester 1 sends 10 bytes without EOP while requester 0 is waiting -> after 4 bytes the grant moves to 0; requester 1 later resumes with byte 5.
- Timeout and reset:
  - IDLE_TIMEOUT=8: granted requester drops valid after 1 byte -> release 8 cycles later.
  - Separately, i_rst mid-message -> next cycle all outputs 0 and requester 0 wins the first arbitration.
